tug_score_ctrl: RTL and testbench

Frame-synchronous score sequencer for the tug-of-war display. It accepts single-cycle point pulses from the left and right players and accumulates them as a net pull. Once per video frame, during the blanking line, it moves the 5-bit rope score one step. It also detects a win, holds the win display for a fixed number of frames, then restarts the round. Its `score` output drives the tug-of-war glyph renderer's `score` input directly, so positions only change between frames.

---
 rtl/tug_pkg.sv | 14 +
 rtl/tug_score_ctrl_if.sv | 27 ++
 rtl/tug_frame_tick.sv | 15 +
 rtl/tug_score_ctrl.sv | 126 ++++++++++++
 tb/tb_tug_score_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/tug_pkg.sv
// Shared constants and state encoding for the tug-of-war score sequencer.
package tug_pkg;

  localparam int SCORE_W         = 5;
  localparam int NET_W           = 4;
  localparam int SCORE_MAX_DEF   = 20;
  localparam int SCORE_START_DEF = 10;

  typedef enum logic {
    PLAY     = 1'b0,
    WIN_HOLD = 1'b1
  } tug_state_e;

endpackage

// File: rtl/tug_score_ctrl_if.sv
// Video-counter, player-input and score-output bundle for tug_score_ctrl.
interface tug_score_ctrl_if;
  import tug_pkg::*;

  logic [9:0]         hPixelCounter;
  logic [9:0]         vPixelCounter;
  logic               gameEnable;
  logic               leftPoint;
  logic               rightPoint;
  logic               newRound;
  logic [SCORE_W-1:0] score;
  logic               winLeft;
  logic               winRight;
  logic               roundActive;

  // Game/video side: drives counters and pulses, observes the score.
  modport master (
    output hPixelCounter, vPixelCounter, gameEnable, leftPoint, rightPoint, newRound,
    input  score, winLeft, winRight, roundActive
  );

  // Score controller side.
  modport slave (
    input  hPixelCounter, vPixelCounter, gameEnable, leftPoint, rightPoint, newRound,
    output score, winLeft, winRight, roundActive
  );
endinterface

// File: rtl/tug_frame_tick.sv
// One-cycle-per-frame strobe at the start of a chosen blanking line.
module tug_frame_tick #(
  parameter int UPDATE_LINE = 490
) (
  input  logic [9:0] hPixelCounter,
  input  logic [9:0] vPixelCounter,
  output logic       frameTick
);

  localparam logic [9:0] LINE = 10'(UPDATE_LINE);

  // Pixel 0 of the update line occurs exactly once per frame.
  always_comb frameTick = (vPixelCounter == LINE) && (hPixelCounter == 10'd0);

endmodule

// File: rtl/tug_score_ctrl.sv
// Frame-synchronous tug-of-war score sequencer: accumulates player pulses into
// a saturating net pull and moves the rope score one step per frame.
module tug_score_ctrl
  import tug_pkg::*;
#(
  parameter int SCORE_MAX   = SCORE_MAX_DEF,
  parameter int SCORE_START = SCORE_START_DEF,
  parameter int NET_MAX     = 7,
  parameter int UPDATE_LINE = 490,
  parameter int HOLD_FRAMES = 120
) (
  input  logic           pixelClk,
  input  logic           rstN,
  tug_score_ctrl_if.slave bus
);

  localparam logic [SCORE_W-1:0]      SMAX   = SCORE_W'(SCORE_MAX);
  localparam logic [SCORE_W-1:0]      SSTART = SCORE_W'(SCORE_START);
  localparam logic [7:0]              HOLD   = 8'(HOLD_FRAMES);
  localparam logic signed [NET_W:0]   NMAX   = (NET_W+1)'(NET_MAX);
  localparam logic signed [NET_W:0]   NMIN   = -NMAX;
  localparam logic signed [NET_W:0]   ONE    = (NET_W+1)'(1);

  tug_state_e                state;
  logic signed [NET_W-1:0]   net;
  logic [7:0]                holdCnt;
  logic [SCORE_W-1:0]        score;
  logic                      winLeft, winRight, roundActive;

  logic                      frameTick;
  logic                      tickPlay, stepUp, stepDn, winR, winL;
  logic [SCORE_W-1:0]        scoreUp, scoreDn;
  logic signed [NET_W:0]     adj, netSum;
  logic signed [NET_W-1:0]   netNx;

  tug_frame_tick #(.UPDATE_LINE(UPDATE_LINE)) uTick (
    .hPixelCounter (bus.hPixelCounter),
    .vPixelCounter (bus.vPixelCounter),
    .frameTick     (frameTick)
  );

  // Frame step decision and the summed, saturated next net value.
  always_comb begin
    tickPlay = frameTick && bus.gameEnable && (state == PLAY);
    stepUp   = tickPlay && !net[NET_W-1] && (net != '0);
    stepDn   = tickPlay && net[NET_W-1];
    scoreUp  = score + 1'b1;
    scoreDn  = score - 1'b1;
    winR     = stepUp && (scoreUp == SMAX);
    winL     = stepDn && (scoreDn == '0);

    adj = '0;
    if (stepUp) adj = adj - ONE;
    if (stepDn) adj = adj + ONE;
    // Simultaneous left and right pulses cancel.
    if (bus.gameEnable && bus.rightPoint && !bus.leftPoint) adj = adj + ONE;
    if (bus.gameEnable && bus.leftPoint && !bus.rightPoint) adj = adj - ONE;

    netSum = $signed({net[NET_W-1], net}) + adj;
    netNx  = netSum[NET_W-1:0];
    if (netSum > NMAX)      netNx = NMAX[NET_W-1:0];
    else if (netSum < NMIN) netNx = NMIN[NET_W-1:0];
  end

  // Round FSM with registered score, flags, net and hold countdown.
  always_ff @(posedge pixelClk or negedge rstN) begin
    if (!rstN) begin
      state       <= PLAY;
      net         <= '0;
      holdCnt     <= '0;
      score       <= SSTART;
      winLeft     <= 1'b0;
      winRight    <= 1'b0;
      roundActive <= 1'b1;
    end else if (bus.newRound) begin
      state       <= PLAY;
      net         <= '0;
      holdCnt     <= '0;
      score       <= SSTART;
      winLeft     <= 1'b0;
      winRight    <= 1'b0;
      roundActive <= 1'b1;
    end else begin
      case (state)
        PLAY: begin
          if (winR || winL) begin
            state       <= WIN_HOLD;
            score       <= winR ? SMAX : '0;
            winRight    <= winR;
            winLeft     <= winL;
            roundActive <= 1'b0;
            net         <= '0;
            holdCnt     <= HOLD;
          end else begin
            net <= netNx;
            if (stepUp)      score <= scoreUp;
            else if (stepDn) score <= scoreDn;
          end
        end
        WIN_HOLD: begin
          // Countdown runs regardless of gameEnable; pulses are ignored here.
          if (frameTick) begin
            if (holdCnt == 8'd1) begin
              state       <= PLAY;
              net         <= '0;
              holdCnt     <= '0;
              score       <= SSTART;
              winLeft     <= 1'b0;
              winRight    <= 1'b0;
              roundActive <= 1'b1;
            end else begin
              holdCnt <= holdCnt - 8'd1;
            end
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

  assign bus.score       = score;
  assign bus.winLeft     = winLeft;
  assign bus.winRight    = winRight;
  assign bus.roundActive = roundActive;

endmodule

// File: tb/tb_tug_score_ctrl.sv
// Self-checking bench for tug_score_ctrl: directed scenarios plus random
// stimulus against a frame-level reference model.
module tb_tug_score_ctrl;

  localparam int SMAX   = 20;
  localparam int SSTART = 10;
  localparam int NMAX   = 7;
  localparam int HOLD   = 120;

  logic pixelClk = 1'b0;
  logic rstN     = 1'b0;
  tug_score_ctrl_if bus();

  tug_score_ctrl dut (
    .pixelClk (pixelClk),
    .rstN     (rstN),
    .bus      (bus)
  );

  always #5 pixelClk = ~pixelClk;

  int total = 0;
  int bad   = 0;

  // Reference model state: rope position, pending pull, frames left in a win.
  int mScore, mNet, mHold;
  bit mWinL, mWinR;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mScore = SSTART; mNet = 0; mHold = 0; mWinL = 0; mWinR = 0;
  endtask

  task automatic modelStep(input bit l, r, nr, tk, en);
    int d, p, dir;
    if (nr) begin
      modelReset();
    end else if (mWinL || mWinR) begin
      if (tk) begin
        if (mHold == 1) modelReset();
        else mHold--;
      end
    end else begin
      d = 0;
      if (tk && en && mNet != 0) begin
        dir = (mNet > 0) ? 1 : -1;
        mScore += dir;
        d = -dir;
      end
      p = en ? (int'(r) - int'(l)) : 0;
      mNet = mNet + d + p;
      if (mNet > NMAX)  mNet = NMAX;
      if (mNet < -NMAX) mNet = -NMAX;
      if (mScore == SMAX) begin mWinR = 1; mNet = 0; mHold = HOLD; end
      if (mScore == 0)    begin mWinL = 1; mNet = 0; mHold = HOLD; end
    end
  endtask

  task automatic checkOut(input string tag);
    chk({tag, ".score"}, int'(bus.score), mScore);
    chk({tag, ".winL"},  int'(bus.winLeft), int'(mWinL));
    chk({tag, ".winR"},  int'(bus.winRight), int'(mWinR));
    chk({tag, ".act"},   int'(bus.roundActive), int'(!(mWinL || mWinR)));
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check after.
  task automatic step(input bit l, r, nr, tk, en, input string tag);
    int v, h;
    bus.leftPoint  = l;
    bus.rightPoint = r;
    bus.newRound   = nr;
    bus.gameEnable = en;
    if (tk) begin
      v = 490; h = 0;
    end else begin
      v = $urandom_range(0, 524);
      h = $urandom_range(0, 799);
      if ($urandom_range(0, 3) == 0) v = 490;
      if ($urandom_range(0, 3) == 0) h = 0;
      if (v == 490 && h == 0) h = 1;
    end
    bus.vPixelCounter = 10'(v);
    bus.hPixelCounter = 10'(h);
    @(posedge pixelClk);
    modelStep(l, r, nr, tk, en);
    @(negedge pixelClk);
    checkOut(tag);
  endtask

  task automatic pulses(input int n, input bit l, input bit r);
    for (int i = 0; i < n; i++) step(l, r, 0, 0, 1, "pulse");
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 1, "tick");
  endtask

  // Asynchronous reset applied mid-cycle; outputs must change before any edge.
  task automatic asyncReset(input string tag);
    #2 rstN = 1'b0;
    #1;
    modelReset();
    chk({tag, ".rstScore"}, int'(bus.score), SSTART);
    chk({tag, ".rstWinL"},  int'(bus.winLeft), 0);
    chk({tag, ".rstWinR"},  int'(bus.winRight), 0);
    chk({tag, ".rstAct"},   int'(bus.roundActive), 1);
    @(negedge pixelClk);
    rstN = 1'b1;
  endtask

  initial begin
    bus.leftPoint = 0; bus.rightPoint = 0; bus.newRound = 0; bus.gameEnable = 1;
    bus.hPixelCounter = 10'd5; bus.vPixelCounter = 10'd0;
    modelReset();
    repeat (2) @(negedge pixelClk);
    checkOut("reset");
    rstN = 1'b1;

    // Three consecutive right pulses move the rope three frames.
    pulses(3, 0, 1);
    step(0, 0, 0, 1, 1, "t1a"); chk("t1.s11", int'(bus.score), 11);
    step(0, 0, 0, 1, 1, "t1b"); chk("t1.s12", int'(bus.score), 12);
    step(0, 0, 0, 1, 1, "t1c"); chk("t1.s13", int'(bus.score), 13);
    ticks(2);                   chk("t1.hold13", int'(bus.score), 13);

    // Net saturation at +7.
    asyncReset("t2");
    pulses(10, 0, 1);
    ticks(9);
    chk("t2.s17", int'(bus.score), 17);

    // Simultaneous pulses cancel, at net 0 and at net +7.
    asyncReset("t3");
    step(1, 1, 0, 0, 1, "t3both0");
    ticks(2);
    chk("t3.net0", int'(bus.score), SSTART);
    pulses(7, 0, 1);
    step(1, 1, 0, 0, 1, "t3both7");
    ticks(9);
    chk("t3.net7", int'(bus.score), 17);

    // Reach the right win, hold for 120 frames with pulses ignored.
    pulses(3, 0, 1);
    ticks(2);
    step(0, 0, 0, 1, 1, "t4win");
    chk("t4.winR", int'(bus.winRight), 1);
    chk("t4.act",  int'(bus.roundActive), 0);
    chk("t4.s20",  int'(bus.score), SMAX);
    for (int i = 0; i < HOLD - 1; i++) step(i[0], 1, 0, 1, 1, "t4hold");
    chk("t4.stillWin", int'(bus.winRight), 1);
    chk("t4.held20",   int'(bus.score), SMAX);
    step(0, 1, 0, 1, 1, "t4end");
    chk("t4.restart", int'(bus.score), SSTART);
    chk("t4.flagClr", int'(bus.winRight), 0);

    // Left win, then newRound together with a tick and a right pulse.
    pulses(7, 1, 0); ticks(7);
    pulses(3, 1, 0); ticks(3);
    chk("t5.winL", int'(bus.winLeft), 1);
    ticks(5);
    step(0, 1, 1, 1, 1, "t5nr");
    chk("t5.nrScore", int'(bus.score), SSTART);
    chk("t5.nrAct",   int'(bus.roundActive), 1);
    ticks(2);
    chk("t5.net0", int'(bus.score), SSTART);

    // Async reset with score 4 and net -2 pending.
    pulses(6, 1, 0); ticks(6);
    chk("t6.s4", int'(bus.score), 4);
    pulses(2, 1, 0);
    asyncReset("t6");
    ticks(3);
    chk("t6.netClr", int'(bus.score), SSTART);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) != 0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
